// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Control unit for a multicycle RV32I-style datapath. It steps through
// FETCH -> DECODE -> EXEC -> (MEM) -> WB with an optional TRAP state, raises
// the memory handshakes, and issues the per-state datapath strobes.
// Instruction decode is purely combinational from the instruction register.
// Both memory handshakes have a bounded wait; when the bound runs out the
// controller raises a bus-error trap.
//
// Parameters
//   TIMEOUT  maximum wait cycles on a memory handshake before trapping
//   CNT_W    width of the handshake wait counter
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   instr             instruction register contents
//   imem_ready        fetch completes this cycle
//   dmem_ready        data access completes this cycle
//   imem_req/dmem_req memory requests
//   ir_we, pc_we      instruction register / PC load strobes
//   aluop             ALU operation (ADD 0 .. PASS-B 10)
//   rf_en             register-file write strobe
//   sel_a, sel_b      ALU operand selects (PC / immediate when 1)
//   sel_wb            write-back source: ALU, memory, PC+4, CSR
//   rd_en, wr_en      data-memory read / write strobes
//   mem_mode          access size (B, H, W, BU, HU, none = 7)
//   br_type           branch funct3, 3'b010 (never taken) otherwise
//   jump              unconditional PC redirect
//   csr_rd, csr_wr    CSR read / write strobe
//   is_mret           return from trap
//   trap, trap_cause  trap strobe and latched cause
//   state             current FSM state for debug
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic [3:0]  aluop,
    output logic        rf_en,
    output logic        sel_a,
    output logic        sel_b,
    output logic [1:0]  sel_wb,
    output logic        rd_en,
    output logic        wr_en,
    output logic [2:0]  mem_mode,
    output logic [2:0]  br_type,
    output logic        jump,
    output logic        csr_rd,
    output logic        csr_wr,
    output logic        is_mret,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] INSTR_MRET = 32'h30200073;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_CSR = 2'd3;

    localparam logic [2:0] MM_B    = 3'd0;
    localparam logic [2:0] MM_H    = 3'd1;
    localparam logic [2:0] MM_W    = 3'd2;
    localparam logic [2:0] MM_BU   = 3'd3;
    localparam logic [2:0] MM_HU   = 3'd4;
    localparam logic [2:0] MM_NONE = 3'd7;

    localparam logic [2:0] BR_NEVER = 3'b010;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
    localparam logic [1:0] CAUSE_IFETCH  = 2'd1;
    localparam logic [1:0] CAUSE_DMEM    = 2'd2;

    // Counter value seen during the last permitted wait cycle. A low ready
    // in that cycle means TIMEOUT cycles have gone by without completion.
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    // ALU operation from funct3; alt selects SUB/SRA where funct7[5] applies
    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // ------------------------------------------------------------------
    // Registers and internal signals
    // ------------------------------------------------------------------
    state_t           state_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [1:0]       trap_cause_r;

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;

    logic [3:0] dec_aluop_s;
    logic       dec_sel_a_s;
    logic       dec_sel_b_s;
    logic [1:0] dec_sel_wb_s;
    logic [2:0] dec_mem_mode_s;
    logic [2:0] dec_br_type_s;
    logic       dec_jump_s;
    logic       dec_csr_rd_s;
    logic       dec_illegal_s;
    logic       dec_load_s;
    logic       dec_store_s;
    logic       dec_rf_s;
    logic       dec_mret_s;
    logic       dec_csrrw_s;

    logic dec_active_s;
    logic fetch_timeout_s;
    logic dmem_timeout_s;

    logic imem_req_s;
    logic dmem_req_s;
    logic ir_we_s;
    logic pc_we_s;
    logic rf_en_s;
    logic rd_en_s;
    logic wr_en_s;
    logic csr_wr_s;
    logic is_mret_s;
    logic trap_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];

    assign fetch_timeout_s = (~imem_ready) & (wait_cnt_r == TERM_CNT);
    assign dmem_timeout_s  = (~dmem_ready) & (wait_cnt_r == TERM_CNT);

    // Instruction decode: datapath controls plus class flags for the FSM
    always_comb begin
        dec_aluop_s    = ALU_ADD;
        dec_sel_a_s    = 1'b0;
        dec_sel_b_s    = 1'b0;
        dec_sel_wb_s   = WB_ALU;
        dec_mem_mode_s = MM_NONE;
        dec_br_type_s  = BR_NEVER;
        dec_jump_s     = 1'b0;
        dec_csr_rd_s   = 1'b0;
        dec_illegal_s  = 1'b0;
        dec_load_s     = 1'b0;
        dec_store_s    = 1'b0;
        dec_rf_s       = 1'b0;
        dec_mret_s     = 1'b0;
        dec_csrrw_s    = 1'b0;
        case (opcode_s)
            OP_R: begin
                if ((funct7_s == 7'b0000000) || (funct7_s == 7'b0100000)) begin
                    dec_aluop_s = alu_sel(funct3_s, funct7_s[5]);
                    dec_rf_s    = 1'b1;
                end else begin
                    dec_illegal_s = 1'b1;
                end
            end
            OP_IMM: begin
                // Only the shift-right immediate carries an alternate form
                dec_aluop_s = alu_sel(funct3_s,
                                      (funct3_s == 3'b101) && (funct7_s == 7'b0100000));
                dec_sel_b_s = 1'b1;
                dec_rf_s    = 1'b1;
            end
            OP_LOAD: begin
                dec_sel_b_s  = 1'b1;
                dec_sel_wb_s = WB_MEM;
                dec_load_s   = 1'b1;
                dec_rf_s     = 1'b1;
                case (funct3_s)
                    3'b000:  dec_mem_mode_s = MM_B;
                    3'b001:  dec_mem_mode_s = MM_H;
                    3'b010:  dec_mem_mode_s = MM_W;
                    3'b100:  dec_mem_mode_s = MM_BU;
                    3'b101:  dec_mem_mode_s = MM_HU;
                    default: begin
                        dec_illegal_s = 1'b1;
                        dec_load_s    = 1'b0;
                        dec_rf_s      = 1'b0;
                    end
                endcase
            end
            OP_STORE: begin
                dec_sel_b_s = 1'b1;
                dec_store_s = 1'b1;
                case (funct3_s)
                    3'b000:  dec_mem_mode_s = MM_B;
                    3'b001:  dec_mem_mode_s = MM_H;
                    3'b010:  dec_mem_mode_s = MM_W;
                    default: begin
                        dec_illegal_s = 1'b1;
                        dec_store_s   = 1'b0;
                    end
                endcase
            end
            OP_BRANCH: begin
                // ALU forms the target PC+imm; the comparison is elsewhere
                dec_sel_a_s = 1'b1;
                dec_sel_b_s = 1'b1;
                if ((funct3_s == 3'b010) || (funct3_s == 3'b011)) begin
                    dec_illegal_s = 1'b1;
                end else begin
                    dec_br_type_s = funct3_s;
                end
            end
            OP_JALR: begin
                dec_sel_b_s  = 1'b1;
                dec_jump_s   = 1'b1;
                dec_sel_wb_s = WB_PC4;
                dec_rf_s     = 1'b1;
            end
            OP_JAL: begin
                dec_sel_a_s  = 1'b1;
                dec_sel_b_s  = 1'b1;
                dec_jump_s   = 1'b1;
                dec_sel_wb_s = WB_PC4;
                dec_rf_s     = 1'b1;
            end
            OP_LUI: begin
                dec_aluop_s = ALU_PASSB;
                dec_sel_b_s = 1'b1;
                dec_rf_s    = 1'b1;
            end
            OP_AUIPC: begin
                dec_sel_a_s = 1'b1;
                dec_sel_b_s = 1'b1;
                dec_rf_s    = 1'b1;
            end
            OP_SYSTEM: begin
                case (funct3_s)
                    3'b000: begin
                        // MRET is the only privileged form supported
                        if (instr == INSTR_MRET) begin
                            dec_mret_s = 1'b1;
                        end else begin
                            dec_illegal_s = 1'b1;
                        end
                    end
                    3'b001: begin
                        dec_sel_wb_s = WB_CSR;
                        dec_csr_rd_s = 1'b1;
                        dec_csrrw_s  = 1'b1;
                        dec_rf_s     = 1'b1;
                    end
                    default: dec_illegal_s = 1'b1;
                endcase
            end
            default: dec_illegal_s = 1'b1;
        endcase
    end

    // State register, handshake wait counter and latched trap cause
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_FETCH;
            wait_cnt_r   <= '0;
            trap_cause_r <= CAUSE_ILLEGAL;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    // A ready in the terminal cycle is checked first, so it wins
                    if (imem_ready) begin
                        state_r <= ST_DECODE;
                    end else if (fetch_timeout_s) begin
                        state_r      <= ST_TRAP;
                        trap_cause_r <= CAUSE_IFETCH;
                        wait_cnt_r   <= wait_cnt_r + CNT_ONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_ONE;
                    end
                end
                ST_DECODE: begin
                    if (dec_illegal_s) begin
                        state_r      <= ST_TRAP;
                        trap_cause_r <= CAUSE_ILLEGAL;
                    end else begin
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (dec_load_s || dec_store_s) begin
                        state_r    <= ST_MEM;
                        wait_cnt_r <= '0;
                    end else begin
                        state_r <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        if (dec_store_s) begin
                            state_r    <= ST_FETCH;
                            wait_cnt_r <= '0;
                        end else begin
                            state_r <= ST_WB;
                        end
                    end else if (dmem_timeout_s) begin
                        state_r      <= ST_TRAP;
                        trap_cause_r <= CAUSE_DMEM;
                        wait_cnt_r   <= wait_cnt_r + CNT_ONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_ONE;
                    end
                end
                ST_WB: begin
                    state_r    <= ST_FETCH;
                    wait_cnt_r <= '0;
                end
                ST_TRAP: begin
                    state_r    <= ST_FETCH;
                    wait_cnt_r <= '0;
                end
                default: begin
                    state_r    <= ST_FETCH;
                    wait_cnt_r <= '0;
                end
            endcase
        end
    end

    // Per-state strobes and requests before reset gating
    always_comb begin
        imem_req_s = 1'b0;
        dmem_req_s = 1'b0;
        ir_we_s    = 1'b0;
        pc_we_s    = 1'b0;
        rf_en_s    = 1'b0;
        rd_en_s    = 1'b0;
        wr_en_s    = 1'b0;
        csr_wr_s   = 1'b0;
        is_mret_s  = 1'b0;
        trap_s     = 1'b0;
        case (state_r)
            ST_FETCH: begin
                imem_req_s = 1'b1;
                ir_we_s    = imem_ready;
            end
            ST_MEM: begin
                dmem_req_s = 1'b1;
                rd_en_s    = dec_load_s;
                wr_en_s    = dec_store_s;
                // Stores retire here, so the PC advances on completion
                pc_we_s    = dec_store_s & dmem_ready;
            end
            ST_WB: begin
                pc_we_s   = 1'b1;
                rf_en_s   = dec_rf_s;
                is_mret_s = dec_mret_s;
                csr_wr_s  = dec_csrrw_s;
            end
            ST_TRAP: begin
                trap_s  = 1'b1;
                pc_we_s = 1'b1;
            end
            default: begin
                imem_req_s = 1'b0;
            end
        endcase
    end

    // Reset kills every side effect in the same cycle, including a pending
    // memory access, so nothing is written while the controller restarts.
    assign imem_req = imem_req_s & ~rst;
    assign dmem_req = dmem_req_s & ~rst;
    assign ir_we    = ir_we_s    & ~rst;
    assign pc_we    = pc_we_s    & ~rst;
    assign rf_en    = rf_en_s    & ~rst;
    assign rd_en    = rd_en_s    & ~rst;
    assign wr_en    = wr_en_s    & ~rst;
    assign csr_wr   = csr_wr_s   & ~rst;
    assign is_mret  = is_mret_s  & ~rst;
    assign trap     = trap_s     & ~rst;

    // Decode controls are only meaningful once an instruction is latched
    assign dec_active_s = (state_r == ST_DECODE) || (state_r == ST_EXEC) ||
                          (state_r == ST_MEM)    || (state_r == ST_WB);

    assign aluop    = dec_active_s ? dec_aluop_s    : ALU_ADD;
    assign sel_a    = dec_active_s ? dec_sel_a_s    : 1'b0;
    assign sel_b    = dec_active_s ? dec_sel_b_s    : 1'b0;
    assign sel_wb   = dec_active_s ? dec_sel_wb_s   : WB_ALU;
    assign mem_mode = dec_active_s ? dec_mem_mode_s : MM_NONE;
    assign br_type  = dec_active_s ? dec_br_type_s  : BR_NEVER;
    assign jump     = dec_active_s ? dec_jump_s     : 1'b0;
    assign csr_rd   = dec_active_s ? dec_csr_rd_s   : 1'b0;

    assign trap_cause = trap_cause_r;
    assign state      = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl (TIMEOUT = 16). Inputs change one time
// unit after the rising edge and outputs are compared another unit later,
// well away from the next edge.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        dmem_req;
    logic        ir_we;
    logic        pc_we;
    logic [3:0]  aluop;
    logic        rf_en;
    logic        sel_a;
    logic        sel_b;
    logic [1:0]  sel_wb;
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  mem_mode;
    logic [2:0]  br_type;
    logic        jump;
    logic        csr_rd;
    logic        csr_wr;
    logic        is_mret;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;

    int tests = 0;
    int fails = 0;

    multicycle_ctrl #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .aluop      (aluop),
        .rf_en      (rf_en),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .sel_wb     (sel_wb),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .mem_mode   (mem_mode),
        .br_type    (br_type),
        .jump       (jump),
        .csr_rd     (csr_rd),
        .csr_wr     (csr_wr),
        .is_mret    (is_mret),
        .trap       (trap),
        .trap_cause (trap_cause),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction in FETCH with both readies high and step into DECODE
    task automatic begin_instr(input logic [31:0] ins, input string tag);
        instr      = ins;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        #1;
        check({tag, "_fetch_state"}, {29'd0, state}, 32'd0);
        tick();
        check({tag, "_decode_state"}, {29'd0, state}, 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        instr      = 32'h0000_0000;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        tick();
        tick();

        // Reset: FETCH, cause 0, strobes forced low even though imem_ready=1
        check("rst_state",    {29'd0, state}, 32'd0);
        check("rst_cause",    {30'd0, trap_cause}, 32'd0);
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_ir_we",    {31'd0, ir_we}, 32'd0);
        check("rst_pc_we",    {31'd0, pc_we}, 32'd0);

        // add x0,x1,x2 with readies high: states 0,1,2,4
        rst   = 1'b0;
        instr = 32'h0020_8033;
        #1;
        check("add_f_imem_req", {31'd0, imem_req}, 32'd1);
        check("add_f_ir_we",    {31'd0, ir_we}, 32'd1);
        check("add_f_mem_mode", {29'd0, mem_mode}, 32'd7);
        check("add_f_br_type",  {29'd0, br_type}, 32'd2);
        tick();
        check("add_d_state", {29'd0, state}, 32'd1);
        check("add_d_aluop", {28'd0, aluop}, 32'd0);
        check("add_d_sel_b", {31'd0, sel_b}, 32'd0);
        tick();
        check("add_e_state", {29'd0, state}, 32'd2);
        check("add_e_rf_en", {31'd0, rf_en}, 32'd0);
        tick();
        check("add_w_state",  {29'd0, state}, 32'd4);
        check("add_w_rf_en",  {31'd0, rf_en}, 32'd1);
        check("add_w_pc_we",  {31'd0, pc_we}, 32'd1);
        check("add_w_sel_wb", {30'd0, sel_wb}, 32'd0);
        tick();
        check("add_next_state", {29'd0, state}, 32'd0);

        // lw x1,0(x2) with dmem_ready low for three MEM cycles
        begin_instr(32'h0001_2083, "lw");
        tick();
        check("lw_e_state", {29'd0, state}, 32'd2);
        dmem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                dmem_ready = 1'b1;
                #1;
            end
            check("lw_m_state",    {29'd0, state}, 32'd3);
            check("lw_m_rd_en",    {31'd0, rd_en}, 32'd1);
            check("lw_m_dmem_req", {31'd0, dmem_req}, 32'd1);
            check("lw_m_mem_mode", {29'd0, mem_mode}, 32'd2);
            check("lw_m_pc_we",    {31'd0, pc_we}, 32'd0);
            tick();
        end
        check("lw_w_state",  {29'd0, state}, 32'd4);
        check("lw_w_sel_wb", {30'd0, sel_wb}, 32'd1);
        check("lw_w_rf_en",  {31'd0, rf_en}, 32'd1);
        check("lw_w_rd_en",  {31'd0, rd_en}, 32'd0);
        tick();
        check("lw_next_state", {29'd0, state}, 32'd0);

        // Fetch timeout: imem_ready low for 16 cycles traps with cause 1
        instr      = 32'h0020_8033;
        imem_ready = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            check("ito_state", {29'd0, state}, 32'd0);
            check("ito_ir_we", {31'd0, ir_we}, 32'd0);
            tick();
        end
        check("ito_trap_state", {29'd0, state}, 32'd5);
        check("ito_trap",       {31'd0, trap}, 32'd1);
        check("ito_cause",      {30'd0, trap_cause}, 32'd1);
        check("ito_pc_we",      {31'd0, pc_we}, 32'd1);
        tick();
        check("ito_next_state", {29'd0, state}, 32'd0);
        check("ito_trap_off",   {31'd0, trap}, 32'd0);

        // Ready arriving exactly in the terminal (16th) wait cycle wins
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        check("ito2_state", {29'd0, state}, 32'd0);
        imem_ready = 1'b1;
        #1;
        check("ito2_ir_we", {31'd0, ir_we}, 32'd1);
        tick();
        check("ito2_decode", {29'd0, state}, 32'd1);
        check("ito2_trap",   {31'd0, trap}, 32'd0);
        tick();
        tick();
        check("ito2_wb", {29'd0, state}, 32'd4);
        tick();

        // Illegal instruction: DECODE -> TRAP, cause back to 0, no rf write
        begin_instr(32'hFFFF_FFFF, "ill");
        check("ill_d_rf_en", {31'd0, rf_en}, 32'd0);
        tick();
        check("ill_t_state", {29'd0, state}, 32'd5);
        check("ill_t_trap",  {31'd0, trap}, 32'd1);
        check("ill_t_cause", {30'd0, trap_cause}, 32'd0);
        check("ill_t_pc_we", {31'd0, pc_we}, 32'd1);
        check("ill_t_rf_en", {31'd0, rf_en}, 32'd0);
        check("ill_t_aluop_zero", {28'd0, aluop}, 32'd0);
        tick();
        check("ill_next_state", {29'd0, state}, 32'd0);
        check("ill_next_rf_en", {31'd0, rf_en}, 32'd0);

        // Data timeout: a load stuck for 16 MEM cycles traps with cause 2
        begin_instr(32'h0001_2083, "dto");
        tick();
        dmem_ready = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            check("dto_m_state", {29'd0, state}, 32'd3);
            tick();
        end
        check("dto_t_state", {29'd0, state}, 32'd5);
        check("dto_t_cause", {30'd0, trap_cause}, 32'd2);
        check("dto_t_rd_en", {31'd0, rd_en}, 32'd0);
        tick();
        dmem_ready = 1'b1;

        // srai x1,x2,3 -> SRA with immediate operand
        begin_instr(32'h4031_5093, "srai");
        check("srai_aluop", {28'd0, aluop}, 32'd7);
        check("srai_sel_b", {31'd0, sel_b}, 32'd1);
        tick();
        tick();
        check("srai_w_rf_en", {31'd0, rf_en}, 32'd1);
        tick();

        // jal x1,0 -> PC+imm through ALU, jump, PC+4 write-back
        begin_instr(32'h0000_00EF, "jal");
        check("jal_jump",   {31'd0, jump}, 32'd1);
        check("jal_sel_a",  {31'd0, sel_a}, 32'd1);
        check("jal_sel_wb", {30'd0, sel_wb}, 32'd2);
        tick();
        tick();
        tick();

        // beq x1,x2,0 -> br_type from funct3, no register write
        begin_instr(32'h0020_8063, "beq");
        check("beq_br_type", {29'd0, br_type}, 32'd0);
        check("beq_sel_b",   {31'd0, sel_b}, 32'd1);
        tick();
        tick();
        check("beq_w_rf_en", {31'd0, rf_en}, 32'd0);
        tick();

        // csrrw x1,0x300,x2 -> CSR write-back, csr_wr in WB
        begin_instr(32'h3001_10F3, "csrrw");
        check("csrrw_sel_wb", {30'd0, sel_wb}, 32'd3);
        check("csrrw_csr_rd", {31'd0, csr_rd}, 32'd1);
        tick();
        tick();
        check("csrrw_w_csr_wr", {31'd0, csr_wr}, 32'd1);
        check("csrrw_w_rf_en",  {31'd0, rf_en}, 32'd1);
        tick();

        // MRET -> is_mret in WB, no register write
        begin_instr(32'h3020_0073, "mret");
        tick();
        tick();
        check("mret_w_state",   {29'd0, state}, 32'd4);
        check("mret_w_is_mret", {31'd0, is_mret}, 32'd1);
        check("mret_w_rf_en",   {31'd0, rf_en}, 32'd0);
        check("mret_w_pc_we",   {31'd0, pc_we}, 32'd1);
        tick();

        // sw x2,0(x1) with readies high: retires from MEM in 4 cycles
        begin_instr(32'h0020_A023, "sw");
        tick();
        tick();
        check("sw_m_state",    {29'd0, state}, 32'd3);
        check("sw_m_wr_en",    {31'd0, wr_en}, 32'd1);
        check("sw_m_rd_en",    {31'd0, rd_en}, 32'd0);
        check("sw_m_pc_we",    {31'd0, pc_we}, 32'd1);
        check("sw_m_mem_mode", {29'd0, mem_mode}, 32'd2);
        tick();
        check("sw_next_state", {29'd0, state}, 32'd0);

        // sw interrupted by reset while waiting in MEM
        begin_instr(32'h0020_A023, "swr");
        tick();
        dmem_ready = 1'b0;
        tick();
        check("swr_m_wr_en", {31'd0, wr_en}, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check("swr_rst_wr_en",    {31'd0, wr_en}, 32'd0);
        check("swr_rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check("swr_rst_pc_we",    {31'd0, pc_we}, 32'd0);
        tick();
        check("swr_after_state", {29'd0, state}, 32'd0);
        check("swr_after_pc_we", {31'd0, pc_we}, 32'd0);
        rst        = 1'b0;
        dmem_ready = 1'b1;
        #1;
        check("swr_fetch_imem_req", {31'd0, imem_req}, 32'd1);
        check("swr_fetch_cause",    {30'd0, trap_cause}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
